// File: rtl/seg_scan_pkg.sv
// Shared constants and bus payload type for the 7-segment scan capture monitor.
// Segment patterns are active-high, ordered {g,f,e,d,c,b,a}.
package seg_scan_pkg;

  localparam int unsigned SEG_W  = 7;
  localparam int unsigned CODE_W = 4;

  localparam logic [SEG_W-1:0] SEG_0     = 7'h3F;
  localparam logic [SEG_W-1:0] SEG_1     = 7'h06;
  localparam logic [SEG_W-1:0] SEG_2     = 7'h5B;
  localparam logic [SEG_W-1:0] SEG_3     = 7'h4F;
  localparam logic [SEG_W-1:0] SEG_4     = 7'h66;
  localparam logic [SEG_W-1:0] SEG_5     = 7'h6D;
  localparam logic [SEG_W-1:0] SEG_6     = 7'h7D;
  localparam logic [SEG_W-1:0] SEG_7     = 7'h07;
  localparam logic [SEG_W-1:0] SEG_8     = 7'h7F;
  localparam logic [SEG_W-1:0] SEG_9     = 7'h6F;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h00;

  localparam logic [CODE_W-1:0] CODE_BLANK = 4'hF;
  localparam logic [CODE_W-1:0] CODE_ERR   = 4'hE;

  // Segment lines plus decimal point as sampled from the bus for one digit slot.
  typedef struct packed {
    logic [SEG_W-1:0] seg;
    logic             dp;
  } seg_sample_t;

endpackage

// File: rtl/seg7_decode.sv
// Combinational 7-segment pattern to 4-bit code decoder.
// Unknown patterns return CODE_ERR with err set.
module seg7_decode
  import seg_scan_pkg::*;
(
  input  logic [SEG_W-1:0]  seg,
  output logic [CODE_W-1:0] code,
  output logic              err
);

  always_comb begin
    code = CODE_ERR;
    err  = 1'b0;
    unique case (seg)
      SEG_0:     code = 4'h0;
      SEG_1:     code = 4'h1;
      SEG_2:     code = 4'h2;
      SEG_3:     code = 4'h3;
      SEG_4:     code = 4'h4;
      SEG_5:     code = 4'h5;
      SEG_6:     code = 4'h6;
      SEG_7:     code = 4'h7;
      SEG_8:     code = 4'h8;
      SEG_9:     code = 4'h9;
      SEG_BLANK: code = CODE_BLANK;
      default: begin
        code = CODE_ERR;
        err  = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/seg_scan_capture.sv
// Receive-side monitor for a multiplexed 7-segment scan bus: qualifies each
// digit window for stability, decodes it and assembles a full frame.
module seg_scan_capture
  import seg_scan_pkg::*;
#(
  parameter int unsigned NUM_DIGIT      = 6,
  parameter int unsigned STABLE_CYC     = 4,
  parameter bit          ENB_ACTIVE_LOW = 1'b1,
  parameter bit          SEG_ACTIVE_LOW = 1'b0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [SEG_W-1:0]            i_seg,
  input  logic                        i_seg_dp,
  input  logic [NUM_DIGIT-1:0]        i_seg_enb,
  output logic [CODE_W*NUM_DIGIT-1:0] o_digit,
  output logic [NUM_DIGIT-1:0]        o_dp,
  output logic [NUM_DIGIT-1:0]        o_dig_vld,
  output logic                        o_frame_done,
  output logic                        o_err_code,
  output logic                        o_err_enb
);

  localparam int unsigned CNT_W = $clog2(STABLE_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYC);
  localparam logic [CNT_W-1:0] CNT_CAP = CNT_W'(STABLE_CYC - 1);

  seg_sample_t            in_sd_c;
  seg_sample_t            r_sd;
  logic [NUM_DIGIT-1:0]   r_enb;
  logic [CNT_W-1:0]       cnt;
  logic [NUM_DIGIT-1:0]   mask;

  logic                   same_c;
  logic                   strobe_c;
  logic [NUM_DIGIT-1:0]   enb_c;
  logic [SEG_W-1:0]       seg_c;
  logic                   dp_c;
  logic                   any_c;
  logic                   multi_c;
  logic                   capture_c;
  logic [NUM_DIGIT-1:0]   mask_set_c;
  logic                   frame_c;
  logic [CODE_W-1:0]      dec_code;
  logic                   dec_err;

  assign in_sd_c = '{seg: i_seg, dp: i_seg_dp};

  // Stability is judged on the registered sample: the counter restarts at the
  // edge that loads a new value, so one strobe fires per window of any length.
  assign same_c   = (in_sd_c == r_sd) && (i_seg_enb == r_enb);
  assign strobe_c = same_c && (cnt == CNT_CAP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sd  <= '0;
      r_enb <= '0;
      cnt   <= '0;
    end else begin
      r_sd  <= in_sd_c;
      r_enb <= i_seg_enb;
      if (!same_c)
        cnt <= '0;
      else if (cnt != CNT_MAX)
        cnt <= cnt + CNT_W'(1);
    end
  end

  // Polarity normalisation: internal enables and segments are active-high.
  assign enb_c = ENB_ACTIVE_LOW ? ~r_enb   : r_enb;
  assign seg_c = SEG_ACTIVE_LOW ? ~r_sd.seg : r_sd.seg;
  assign dp_c  = SEG_ACTIVE_LOW ? ~r_sd.dp  : r_sd.dp;

  assign any_c      = |enb_c;
  assign multi_c    = |(enb_c & (enb_c - NUM_DIGIT'(1)));
  assign capture_c  = strobe_c && any_c && !multi_c;
  assign mask_set_c = mask | enb_c;
  assign frame_c    = capture_c && (&mask_set_c);

  seg7_decode u_decode (
    .seg  (seg_c),
    .code (dec_code),
    .err  (dec_err)
  );

  // Per-digit storage, frame mask and event pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_digit      <= '0;
      o_dp         <= '0;
      o_dig_vld    <= '0;
      mask         <= '0;
      o_frame_done <= 1'b0;
      o_err_code   <= 1'b0;
      o_err_enb    <= 1'b0;
    end else begin
      o_frame_done <= frame_c;
      o_err_code   <= capture_c && dec_err;
      o_err_enb    <= strobe_c && multi_c;
      if (capture_c) begin
        mask      <= frame_c ? '0 : mask_set_c;
        o_dig_vld <= o_dig_vld | enb_c;
        for (int n = 0; n < NUM_DIGIT; n++) begin
          if (enb_c[n]) begin
            o_digit[CODE_W*n +: CODE_W] <= dec_code;
            o_dp[n]                     <= dp_c;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_capture.sv
// Directed self-checking bench for seg_scan_capture (STABLE_CYC=4,
// active-low enables, active-high segments).
module tb_seg_scan_capture;

  logic        clk;
  logic        rst_n;
  logic [6:0]  i_seg;
  logic        i_seg_dp;
  logic [5:0]  i_seg_enb;
  logic [23:0] o_digit;
  logic [5:0]  o_dp;
  logic [5:0]  o_dig_vld;
  logic        o_frame_done;
  logic        o_err_code;
  logic        o_err_enb;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int fd_cnt = 0;
  int ec_cnt = 0;
  int ee_cnt = 0;
  int fd_cyc = 0;
  int apply_cyc = 0;

  seg_scan_capture #(
    .NUM_DIGIT(6), .STABLE_CYC(4), .ENB_ACTIVE_LOW(1'b1), .SEG_ACTIVE_LOW(1'b0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .i_seg(i_seg), .i_seg_dp(i_seg_dp), .i_seg_enb(i_seg_enb),
    .o_digit(o_digit), .o_dp(o_dp), .o_dig_vld(o_dig_vld),
    .o_frame_done(o_frame_done), .o_err_code(o_err_code), .o_err_enb(o_err_enb)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse counters sampled mid-cycle.
  always @(negedge clk) begin
    if (o_frame_done === 1'b1) begin
      fd_cnt = fd_cnt + 1;
      fd_cyc = cyc;
    end
    if (o_err_code === 1'b1) ec_cnt = ec_cnt + 1;
    if (o_err_enb === 1'b1) ee_cnt = ee_cnt + 1;
  end

  function automatic logic [6:0] seg_of(input int v);
    case (v)
      0: seg_of = 7'h3F;  1: seg_of = 7'h06;  2: seg_of = 7'h5B;
      3: seg_of = 7'h4F;  4: seg_of = 7'h66;  5: seg_of = 7'h6D;
      6: seg_of = 7'h7D;  7: seg_of = 7'h07;  8: seg_of = 7'h7F;
      9: seg_of = 7'h6F;  default: seg_of = 7'h00;
    endcase
  endfunction

  // Apply a bus value 2 time units after an edge and hold it for n edges.
  task automatic drive(input logic [5:0] enb, input logic [6:0] seg, input logic dp, input int n);
    i_seg_enb = enb;
    i_seg     = seg;
    i_seg_dp  = dp;
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Scan digits first..last of "123456", dp lit on digit 2, 8-cycle windows, 2-cycle gaps.
  task automatic scan_digits(input int first, input int last);
    logic [5:0] enb;
    for (int d = first; d <= last; d++) begin
      enb = ~(6'b000001 << d);
      apply_cyc = cyc;
      drive(enb, seg_of(6 - d), (d == 2), 8);
      drive(6'h3F, 7'h00, 1'b0, 2);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(6'($urandom), 7'($urandom), 1'($urandom), 1);
      checks++;
      if ({o_digit, o_dp, o_dig_vld, o_frame_done, o_err_code, o_err_enb} !== 39'h0) begin
        errors++;
        $display("FAIL reset_hold[%0d]: got digit=%h dp=%h vld=%h fd=%b ec=%b ee=%b want all 0",
                 i, o_digit, o_dp, o_dig_vld, o_frame_done, o_err_code, o_err_enb);
      end
    end
    i_seg_enb = 6'h3F; i_seg = 7'h00; i_seg_dp = 1'b0;
    rst_n = 1'b1;
    drive(6'h3F, 7'h00, 1'b0, 10);
    checks++;
    if ({o_digit, o_dp, o_dig_vld} !== 36'h0) begin
      errors++;
      $display("FAIL reset_idle: got digit=%h dp=%h vld=%h want 0", o_digit, o_dp, o_dig_vld);
    end
    checks++;
    if (fd_cnt + ec_cnt + ee_cnt !== 0) begin
      errors++;
      $display("FAIL reset_pulses: got fd=%0d ec=%0d ee=%0d want 0", fd_cnt, ec_cnt, ee_cnt);
    end
  endtask

  task automatic test_scan;
    int fd0;
    fd0 = fd_cnt;
    scan_digits(0, 4);
    checks++;
    if (o_dig_vld !== 6'h1F || fd_cnt !== fd0) begin
      errors++;
      $display("FAIL scan_partial: got vld=%h fd=%0d want vld=1f fd=%0d", o_dig_vld, fd_cnt - fd0, 0);
    end
    scan_digits(5, 5);
    checks++;
    if (o_digit !== 24'h123456) begin
      errors++;
      $display("FAIL scan_digit: got %h want 123456", o_digit);
    end
    checks++;
    if (o_dig_vld !== 6'h3F || o_dp !== 6'h04) begin
      errors++;
      $display("FAIL scan_vld_dp: got vld=%h dp=%h want vld=3f dp=04", o_dig_vld, o_dp);
    end
    checks++;
    if (fd_cnt - fd0 !== 1) begin
      errors++;
      $display("FAIL scan_frame_cnt: got %0d pulses want 1", fd_cnt - fd0);
    end
    checks++;
    if (fd_cyc - apply_cyc !== 5) begin
      errors++;
      $display("FAIL scan_latency: got %0d edges want 5", fd_cyc - apply_cyc);
    end
    checks++;
    if (ec_cnt + ee_cnt !== 0) begin
      errors++;
      $display("FAIL scan_err: got ec=%0d ee=%0d want 0", ec_cnt, ee_cnt);
    end
  endtask

  task automatic test_glitch;
    int fd0;
    fd0 = fd_cnt;
    drive(6'h3E, 7'h06, 1'b0, 3);
    drive(6'h3F, 7'h00, 1'b0, 8);
    checks++;
    if (o_digit !== 24'h123456 || o_dig_vld !== 6'h3F) begin
      errors++;
      $display("FAIL glitch: got digit=%h vld=%h want 123456 3f", o_digit, o_dig_vld);
    end
    checks++;
    if (fd_cnt !== fd0 || ec_cnt + ee_cnt !== 0) begin
      errors++;
      $display("FAIL glitch_pulses: got fd=%0d ec=%0d ee=%0d want 0", fd_cnt - fd0, ec_cnt, ee_cnt);
    end
  endtask

  task automatic test_multi_hot;
    int ee0;
    int fd0;
    ee0 = ee_cnt;
    fd0 = fd_cnt;
    drive(6'h3C, 7'h3F, 1'b0, 10);
    drive(6'h3F, 7'h00, 1'b0, 2);
    checks++;
    if (ee_cnt - ee0 !== 1) begin
      errors++;
      $display("FAIL multi_err_enb: got %0d pulses want 1", ee_cnt - ee0);
    end
    checks++;
    if (o_digit !== 24'h123456 || o_dp !== 6'h04 || fd_cnt !== fd0) begin
      errors++;
      $display("FAIL multi_nochange: got digit=%h dp=%h fd=%0d want 123456 04 0", o_digit, o_dp, fd_cnt - fd0);
    end
  endtask

  task automatic test_bad_pattern;
    int ec0;
    ec0 = ec_cnt;
    drive(6'h3E, 7'h49, 1'b0, 6);
    checks++;
    if (o_digit !== 24'h12345E) begin
      errors++;
      $display("FAIL bad_code: got %h want 12345e", o_digit);
    end
    checks++;
    if (ec_cnt - ec0 !== 1) begin
      errors++;
      $display("FAIL bad_err_code: got %0d pulses want 1", ec_cnt - ec0);
    end
    drive(6'h3E, 7'h00, 1'b0, 6);
    drive(6'h3F, 7'h00, 1'b0, 2);
    checks++;
    if (o_digit !== 24'h12345F || ec_cnt - ec0 !== 1) begin
      errors++;
      $display("FAIL blank_code: got digit=%h ec=%0d want 12345f 1", o_digit, ec_cnt - ec0);
    end
  endtask

  task automatic test_reset_mid_frame;
    int fd0;
    fd0 = fd_cnt;
    scan_digits(0, 2);
    checks++;
    if (fd_cnt !== fd0 || o_digit !== 24'h123456) begin
      errors++;
      $display("FAIL mid_pre: got fd=%0d digit=%h want 0 123456", fd_cnt - fd0, o_digit);
    end
    rst_n = 1'b0;
    #5;
    checks++;
    if ({o_digit, o_dp, o_dig_vld, o_frame_done, o_err_code, o_err_enb} !== 39'h0) begin
      errors++;
      $display("FAIL mid_reset: got digit=%h dp=%h vld=%h want 0", o_digit, o_dp, o_dig_vld);
    end
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    drive(6'h3F, 7'h00, 1'b0, 4);
    scan_digits(0, 4);
    checks++;
    if (fd_cnt !== fd0 || o_dig_vld !== 6'h1F || o_digit !== 24'h023456) begin
      errors++;
      $display("FAIL mid_rescan: got fd=%0d vld=%h digit=%h want 0 1f 023456",
               fd_cnt - fd0, o_dig_vld, o_digit);
    end
    scan_digits(5, 5);
    checks++;
    if (fd_cnt - fd0 !== 1 || fd_cyc - apply_cyc !== 5 || o_digit !== 24'h123456) begin
      errors++;
      $display("FAIL mid_frame: got fd=%0d lat=%0d digit=%h want 1 5 123456",
               fd_cnt - fd0, fd_cyc - apply_cyc, o_digit);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    i_seg = 7'h00;
    i_seg_dp = 1'b0;
    i_seg_enb = 6'h3F;
    test_reset;
    test_scan;
    test_glitch;
    test_multi_hot;
    test_bad_pattern;
    test_reset_mid_frame;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
